l1d_data_ram_ctrl: RTL and testbench

//  Data-RAM request responder: sink of pack_data_ram_req_pld requests from the MSHR bypass port and the MSHR replay port.

---
 rtl/l1d_data_ram_ctrl.sv | 173 +++++++++++++++++
 tb/tb_l1d_data_ram_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1d_data_ram_ctrl.sv
// L1D data-RAM controller: arbitrates the MSHR replay and bypass ports onto a single-port SRAM,
// pipelines the fixed read latency and returns in-order completions through a credit-guarded FIFO.
package l1d_data_ram_pkg;
  localparam int L1D_WAY_NUM  = 4;
  localparam int L1D_SET_NUM  = 64;
  localparam int L1D_WORD_NUM = 8;
  localparam int L1D_WORD_W   = 64;
  localparam int L1D_IDX_W    = $clog2(L1D_SET_NUM);
  localparam int L1D_WAY_W    = $clog2(L1D_WAY_NUM);
  localparam int L1D_OFF_W    = $clog2(L1D_WORD_NUM);
  localparam int L1D_AW       = L1D_IDX_W + L1D_WAY_W + L1D_OFF_W;
  localparam int L1D_SB_W     = 8;

  typedef struct packed {
    logic [L1D_SB_W-1:0] sb_id;
  } pack_sb_pld;

  typedef struct packed {
    logic                      rw_type;
    logic [L1D_IDX_W-1:0]      index;
    logic [L1D_OFF_W-1:0]      offset;
    logic [L1D_WAY_W-1:0]      way;
    logic [L1D_WORD_W-1:0]     wr_data;
    logic [L1D_WORD_W/8-1:0]   wr_data_byte_en;
    pack_sb_pld                wr_sb_pld;
  } pack_data_ram_req_pld;
endpackage

module l1d_data_ram_ctrl
  import l1d_data_ram_pkg::*;
#(
  // Geometry must match the payload structs in l1d_data_ram_pkg.
  parameter int WAY_NUM        = L1D_WAY_NUM,
  parameter int SET_NUM        = L1D_SET_NUM,
  parameter int WORD_NUM       = L1D_WORD_NUM,
  parameter int WORD_W         = L1D_WORD_W,
  parameter int RAM_RD_LAT     = 2,
  parameter int RSP_FIFO_DEPTH = 4,
  localparam int AW   = $clog2(SET_NUM) + $clog2(WAY_NUM) + $clog2(WORD_NUM),
  localparam int BE_W = WORD_W / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bps_req_vld,
  input  pack_data_ram_req_pld bps_req_pld,
  output logic                 data_ram_rdy,
  input  logic                 mshr_req_vld,
  input  pack_data_ram_req_pld mshr_req_pld,
  output logic                 mshr_req_rdy,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [AW-1:0]        sram_addr,
  output logic [BE_W-1:0]      sram_be,
  output logic [WORD_W-1:0]    sram_wdata,
  input  logic [WORD_W-1:0]    sram_rdata,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic                 rsp_rw_type,
  output logic [WORD_W-1:0]    rsp_rdata,
  output pack_sb_pld           rsp_sb_pld
);

  localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        fifo_cnt;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 cnt_ok;
  logic                 acc_mshr;
  logic                 acc_bps;
  logic                 acc;
  logic                 push;
  logic                 pop;
  pack_data_ram_req_pld win;

  logic [RAM_RD_LAT-1:0] pipe_vld;
  logic [RAM_RD_LAT-1:0] pipe_rw;
  pack_sb_pld            pipe_sb [RAM_RD_LAT];

  logic                  fifo_rw    [RSP_FIFO_DEPTH];
  logic [WORD_W-1:0]     fifo_rdata [RSP_FIFO_DEPTH];
  pack_sb_pld            fifo_sb    [RSP_FIFO_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // cnt counts every request holding a completion slot, so the FIFO can never overflow.
  always_comb begin
    cnt_ok       = cnt < CW'(RSP_FIFO_DEPTH);
    mshr_req_rdy = cnt_ok && !rst;
    data_ram_rdy = cnt_ok && !rst && !mshr_req_vld;
    acc_mshr     = mshr_req_vld && mshr_req_rdy;
    acc_bps      = bps_req_vld && data_ram_rdy;
    acc          = acc_mshr || acc_bps;
    win          = acc_mshr ? mshr_req_pld : bps_req_pld;
    sram_en      = acc;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_be      = '0;
    sram_wdata   = '0;
    if (acc) begin
      sram_we    = win.rw_type;
      sram_addr  = {win.index, win.way, win.offset};
      sram_be    = win.wr_data_byte_en;
      sram_wdata = win.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= acc;
      for (int i = 1; i < RAM_RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      pipe_rw[0] <= win.rw_type;
      pipe_sb[0] <= win.wr_sb_pld;
    end
    for (int i = 1; i < RAM_RD_LAT; i++) begin
      pipe_rw[i] <= pipe_rw[i-1];
      pipe_sb[i] <= pipe_sb[i-1];
    end
  end

  assign push    = pipe_vld[RAM_RD_LAT-1];
  assign rsp_vld = (fifo_cnt != '0);
  assign pop     = rsp_vld && rsp_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      cnt      <= cnt + CW'(acc) - CW'(pop);
    end
  end

  // Writes reach the FIFO with zero data; sram_rdata is only meaningful for reads.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[wr_ptr]    <= pipe_rw[RAM_RD_LAT-1];
      fifo_rdata[wr_ptr] <= pipe_rw[RAM_RD_LAT-1] ? '0 : sram_rdata;
      fifo_sb[wr_ptr]    <= pipe_sb[RAM_RD_LAT-1];
    end
    if (!rst && push) begin
      assert (fifo_cnt < CW'(RSP_FIFO_DEPTH));
    end
  end

  always_comb begin
    rsp_rw_type = 1'b0;
    rsp_rdata   = '0;
    rsp_sb_pld  = '0;
    if (rsp_vld) begin
      rsp_rw_type = fifo_rw[rd_ptr];
      rsp_rdata   = fifo_rdata[rd_ptr];
      rsp_sb_pld  = fifo_sb[rd_ptr];
    end
  end

endmodule

// File: tb/tb_l1d_data_ram_ctrl.sv
// Randomized bench for l1d_data_ram_ctrl against a queue-based completion model and an SRAM array model.
module tb_l1d_data_ram_ctrl;
  import l1d_data_ram_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int AW    = L1D_AW;
  localparam int WW    = L1D_WORD_W;

  typedef struct {
    logic          rw;
    logic [WW-1:0] rdata;
    logic [7:0]    sb;
    int            vis;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 bps_req_vld;
  pack_data_ram_req_pld bps_req_pld;
  logic                 data_ram_rdy;
  logic                 mshr_req_vld;
  pack_data_ram_req_pld mshr_req_pld;
  logic                 mshr_req_rdy;
  logic                 sram_en;
  logic                 sram_we;
  logic [AW-1:0]        sram_addr;
  logic [WW/8-1:0]      sram_be;
  logic [WW-1:0]        sram_wdata;
  logic [WW-1:0]        sram_rdata;
  logic                 rsp_vld;
  logic                 rsp_rdy;
  logic                 rsp_rw_type;
  logic [WW-1:0]        rsp_rdata;
  pack_sb_pld           rsp_sb_pld;

  exp_t          exp_q[$];
  logic [WW-1:0] ram_model [1 << AW];
  logic [WW-1:0] sched_data [16];
  logic          sched_vld  [16];
  int            cyc;
  int            checks;
  int            failures;
  int            bps_acc_seen;

  l1d_data_ram_ctrl #(
    .RAM_RD_LAT     (LAT),
    .RSP_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bps_req_vld  (bps_req_vld),
    .bps_req_pld  (bps_req_pld),
    .data_ram_rdy (data_ram_rdy),
    .mshr_req_vld (mshr_req_vld),
    .mshr_req_pld (mshr_req_pld),
    .mshr_req_rdy (mshr_req_rdy),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_be      (sram_be),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .rsp_vld      (rsp_vld),
    .rsp_rdy      (rsp_rdy),
    .rsp_rw_type  (rsp_rw_type),
    .rsp_rdata    (rsp_rdata),
    .rsp_sb_pld   (rsp_sb_pld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic pack_data_ram_req_pld randPld();
    pack_data_ram_req_pld p;
    p.rw_type         = 1'($urandom_range(0, 1));
    p.index           = L1D_IDX_W'($urandom);
    p.offset          = L1D_OFF_W'($urandom);
    p.way             = L1D_WAY_W'($urandom);
    p.wr_data         = {$urandom, $urandom};
    p.wr_data_byte_en = 8'($urandom);
    p.wr_sb_pld       = 8'($urandom);
    return p;
  endfunction

  // One clock cycle: drive at the falling edge, check settled outputs, then advance the model.
  task automatic applyStimulus(input logic r, input logic mv, input pack_data_ram_req_pld mp,
                               input logic bv, input pack_data_ram_req_pld bp, input logic rr);
    logic                 exp_rdy;
    logic                 m_acc;
    logic                 b_acc;
    logic                 any_acc;
    logic                 exp_vld;
    pack_data_ram_req_pld w;
    logic [AW-1:0]        a;
    exp_t                 e;
    int                   slot;
    @(negedge clk);
    rst          = r;
    mshr_req_vld = mv;
    mshr_req_pld = mp;
    bps_req_vld  = bv;
    bps_req_pld  = bp;
    rsp_rdy      = rr;
    slot = cyc % 16;
    if (sched_vld[slot]) begin
      sram_rdata      = sched_data[slot];
      sched_vld[slot] = 1'b0;
    end else begin
      sram_rdata = {$urandom, $urandom};
    end
    #1;
    exp_rdy = !r && (exp_q.size() < DEPTH);
    m_acc   = mv && exp_rdy;
    b_acc   = bv && exp_rdy && !mv;
    any_acc = m_acc || b_acc;
    w       = m_acc ? mp : bp;
    a       = {w.index, w.way, w.offset};
    checkOutput("mshr_req_rdy", 64'(mshr_req_rdy), 64'(exp_rdy));
    checkOutput("data_ram_rdy", 64'(data_ram_rdy), 64'(exp_rdy && !mv));
    checkOutput("sram_en", 64'(sram_en), 64'(any_acc));
    checkOutput("sram_we", 64'(sram_we), any_acc ? 64'(w.rw_type) : 64'(0));
    checkOutput("sram_addr", 64'(sram_addr), any_acc ? 64'(a) : 64'(0));
    checkOutput("sram_be", 64'(sram_be), any_acc ? 64'(w.wr_data_byte_en) : 64'(0));
    checkOutput("sram_wdata", sram_wdata, any_acc ? w.wr_data : 64'(0));
    if (!r && bv && data_ram_rdy) bps_acc_seen++;
    if (!r) begin
      exp_vld = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
      checkOutput("rsp_vld", 64'(rsp_vld), 64'(exp_vld));
      checkOutput("rsp_rw_type", 64'(rsp_rw_type), exp_vld ? 64'(exp_q[0].rw) : 64'(0));
      checkOutput("rsp_rdata", rsp_rdata, exp_vld ? exp_q[0].rdata : 64'(0));
      checkOutput("rsp_sb_pld", 64'(rsp_sb_pld), exp_vld ? 64'(exp_q[0].sb) : 64'(0));
      if (exp_vld && rr) void'(exp_q.pop_front());
    end
    if (r) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) sched_vld[i] = 1'b0;
    end else if (any_acc) begin
      e.rw  = w.rw_type;
      e.sb  = w.wr_sb_pld;
      e.vis = cyc + LAT + 1;
      if (w.rw_type) begin
        e.rdata = '0;
        for (int b = 0; b < WW / 8; b++)
          if (w.wr_data_byte_en[b]) ram_model[a][8*b +: 8] = w.wr_data[8*b +: 8];
      end else begin
        e.rdata = ram_model[a];
        sched_data[(cyc + LAT) % 16] = ram_model[a];
        sched_vld[(cyc + LAT) % 16]  = 1'b1;
      end
      exp_q.push_back(e);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, randPld(), 1'b0, randPld(), 1'b1);
  endtask

  pack_data_ram_req_pld p;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    bps_acc_seen = 0;
    rst = 1'b1;
    mshr_req_vld = 1'b0;
    bps_req_vld = 1'b0;
    mshr_req_pld = '0;
    bps_req_pld = '0;
    rsp_rdy = 1'b0;
    sram_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) ram_model[i] = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) sched_vld[i] = 1'b0;

    repeat (2) applyStimulus(1'b1, 1'b0, randPld(), 1'b0, randPld(), 1'b1);

    p = randPld();
    p.rw_type = 1'b0;
    p.index   = L1D_IDX_W'(5);
    p.way     = L1D_WAY_W'(2);
    p.offset  = L1D_OFF_W'(3);
    applyStimulus(1'b0, 1'b0, randPld(), 1'b1, p, 1'b1);
    idle(6);

    applyStimulus(1'b0, 1'b1, randPld(), 1'b1, randPld(), 1'b1);
    applyStimulus(1'b0, 1'b0, randPld(), 1'b1, randPld(), 1'b1);
    idle(8);

    // Credit exhaustion with the consumer stalled, then a single pop frees one slot.
    bps_acc_seen = 0;
    repeat (6) applyStimulus(1'b0, 1'b0, randPld(), 1'b1, randPld(), 1'b0);
    checkOutput("bp_accepted_first", 64'(bps_acc_seen), 64'(DEPTH));
    repeat (2) applyStimulus(1'b0, 1'b0, randPld(), 1'b1, randPld(), 1'b0);
    applyStimulus(1'b0, 1'b0, randPld(), 1'b1, randPld(), 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, randPld(), 1'b1, randPld(), 1'b0);
    checkOutput("bp_accepted_total", 64'(bps_acc_seen), 64'(DEPTH + 1));
    idle(10);

    p = randPld();
    p.rw_type         = 1'b1;
    p.wr_data_byte_en = 8'h0F;
    p.wr_data         = 64'h1122334455667788;
    applyStimulus(1'b0, 1'b1, p, 1'b0, randPld(), 1'b1);
    idle(6);

    // Reset with two completions queued and two still in the read pipeline.
    repeat (4) applyStimulus(1'b0, 1'b0, randPld(), 1'b1, randPld(), 1'b0);
    applyStimulus(1'b1, 1'b0, randPld(), 1'b0, randPld(), 1'b1);
    idle(8);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 1)), randPld(),
                    1'($urandom_range(0, 1)), randPld(),
                    1'($urandom_range(0, 3) != 0));
    end
    idle(12);
    checkOutput("drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
